// File: rtl/pixel_pkg.sv
// Shared pixel-path types and helpers: default channel geometry, channel slice/pack,
// and the signed saturating shift used by this and later colour blocks.
package pixel_pkg;

    localparam int DEF_CH_W   = 4;
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_PIX_W  = DEF_CH_W * DEF_NUM_CH;

    // Channel 0 is the least-significant slice (B); the top slice is R.
    function automatic logic [DEF_CH_W-1:0] get_chan(input logic [DEF_PIX_W-1:0] pix,
                                                     input int c);
        return pix[c*DEF_CH_W +: DEF_CH_W];
    endfunction

    function automatic logic [DEF_PIX_W-1:0] put_chan(input logic [DEF_PIX_W-1:0] pix,
                                                      input int c,
                                                      input logic [DEF_CH_W-1:0] chan);
        logic [DEF_PIX_W-1:0] res;
        res = pix;
        res[c*DEF_CH_W +: DEF_CH_W] = chan;
        return res;
    endfunction

    // Negative level darkens by right shift; positive brightens, clamping to all-ones
    // whenever a set bit would be shifted out of the top.
    function automatic logic [DEF_CH_W-1:0] sat_shift(input logic [DEF_CH_W-1:0] chan,
                                                      input int lvl);
        int k;
        logic [DEF_CH_W-1:0] res;
        k   = 0;
        res = chan;
        if (lvl < 0) begin
            k   = -lvl;
            res = (k >= DEF_CH_W) ? '0 : (chan >> k);
        end else if (lvl > 0) begin
            k = lvl;
            if (k >= DEF_CH_W)
                res = (chan != '0) ? '1 : '0;
            else if ((chan >> (DEF_CH_W - k)) != '0)
                res = '1;
            else
                res = chan << k;
        end
        return res;
    endfunction

endpackage

// File: rtl/pixel_brightness_scaler_if.sv
// Pixel stream in/out of the brightness scaler; master drives pixels, slave returns them.
// No backpressure: valid qualifies data every cycle.
interface pixel_brightness_scaler_if
    import pixel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
);
    logic             pixValid;
    logic [PIX_W-1:0] pixIn;
    logic [PIX_W-1:0] pixOut;
    logic             pixOutValid;

    modport master (output pixValid, pixIn, input pixOut, pixOutValid);
    modport slave  (input pixValid, pixIn, output pixOut, pixOutValid);
endinterface

// File: rtl/pixel_brightness_scaler_button_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level plus a one-cycle rising-edge pulse.
// Pulse appears two cycles after the input rises; no backpressure.
module button_edge_sync (
    input  logic clk,
    input  logic rstN,
    input  logic btn,
    output logic pulse
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;
endmodule

// File: rtl/pixel_brightness_scaler.sv
// Per-channel signed brightness shift with button-stepped level applied at frame boundaries.
// Fixed 2-cycle pixel latency, never stalls; downstream must always accept.
module pixel_brightness_scaler
    import pixel_pkg::*;
#(
    parameter int CH_W      = DEF_CH_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int MAX_LEVEL = 4,
    parameter bit WRAP      = 1'b0,
    parameter int LVL_W     = $clog2(MAX_LEVEL+1)+1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    stepUp,
    input  logic                    stepDn,
    input  logic                    frameStart,
    pixel_brightness_scaler_if.slave pix,
    output logic [LVL_W-1:0]        level,
    output logic                    levelPending
);
    localparam int PIX_W = NUM_CH * CH_W;
    localparam int MAG_W = LVL_W - 1;
    localparam logic signed [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
    localparam logic signed [LVL_W-1:0] LVL_MIN = -LVL_MAX;

    logic up_pulse;
    logic dn_pulse;

    button_edge_sync u_sync_up (.clk(clk), .rstN(rstN), .btn(stepUp), .pulse(up_pulse));
    button_edge_sync u_sync_dn (.clk(clk), .rstN(rstN), .btn(stepDn), .pulse(dn_pulse));

    logic signed [LVL_W-1:0] pending_q, pending_d;
    logic signed [LVL_W-1:0] active_q, active_d;
    logic                    level_pending_q;

    always_comb begin
        pending_d = pending_q;
        if (up_pulse && !dn_pulse) begin
            if (pending_q == LVL_MAX)
                pending_d = WRAP ? LVL_MIN : LVL_MAX;
            else
                pending_d = pending_q + LVL_W'(1);
        end else if (dn_pulse && !up_pulse) begin
            if (pending_q == LVL_MIN)
                pending_d = WRAP ? LVL_MAX : LVL_MIN;
            else
                pending_d = pending_q - LVL_W'(1);
        end
        // Frame boundary takes the pending value from before this edge; a
        // simultaneous step only moves pending and waits for the next frame.
        active_d = frameStart ? pending_q : active_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending_q       <= '0;
            active_q        <= '0;
            level_pending_q <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            active_q        <= active_d;
            level_pending_q <= (pending_d != active_d);
        end
    end

    assign level        = active_q;
    assign levelPending = level_pending_q;

    logic [LVL_W-1:0] active_abs;
    assign active_abs = active_q[LVL_W-1] ? LVL_W'(-active_q) : LVL_W'(active_q);

    logic             s1_vld;
    logic [PIX_W-1:0] s1_pix;
    logic             s1_neg;
    logic [MAG_W-1:0] s1_mag;
    logic             s2_vld_q;
    logic [PIX_W-1:0] s2_pix_q;
    logic [PIX_W-1:0] s2_pix_d;
    int               s1_lvl;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_vld <= 1'b0;
            s1_pix <= '0;
            s1_neg <= 1'b0;
            s1_mag <= '0;
        end else begin
            s1_vld <= pix.pixValid;
            s1_pix <= pix.pixIn;
            s1_neg <= active_q[LVL_W-1];
            s1_mag <= MAG_W'(active_abs);
        end
    end

    always_comb begin
        s1_lvl   = s1_neg ? -int'(s1_mag) : int'(s1_mag);
        s2_pix_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            s2_pix_d = put_chan(s2_pix_d, c, sat_shift(get_chan(s1_pix, c), s1_lvl));
    end

    // Output data is only refreshed for valid pixels to keep the bus quiet.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s2_vld_q <= 1'b0;
            s2_pix_q <= '0;
        end else begin
            s2_vld_q <= s1_vld;
            if (s1_vld)
                s2_pix_q <= s2_pix_d;
        end
    end

    assign pix.pixOut      = s2_pix_q;
    assign pix.pixOutValid = s2_vld_q;
endmodule
